operand_fetch: RTL and testbench

Operand-fetch sequencer sitting between instruction decode and the execute stage, acting as the reader of the 8-entry register array. It accepts one decoded instruction at a time and drives the array's two read addresses. It samples both operands, holds off on read-after-write hazards using an 8-bit busy scoreboard, and bypasses same-cycle writeback data. It then presents the operand pair to execute with a valid/ready handshake.

---
 rtl/operand_fetch.sv | 125 ++++++++++++
 tb/tb_operand_fetch.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Operand-fetch sequencer: latches one decoded instruction, waits out RAW hazards
// against a busy scoreboard (with writeback bypass), then hands operands to execute.
module operand_fetch #(
    parameter int BITS_DATA = 32,
    parameter int BITS_ADDR = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issueValid,
    output logic                 issueReady,
    input  logic [BITS_ADDR-1:0] issueRs1,
    input  logic [BITS_ADDR-1:0] issueRs2,
    input  logic [BITS_ADDR-1:0] issueRd,
    input  logic                 issueWe,
    output logic [BITS_ADDR-1:0] rfAddr1,
    output logic [BITS_ADDR-1:0] rfAddr2,
    input  logic [BITS_DATA-1:0] rfData1,
    input  logic [BITS_DATA-1:0] rfData2,
    input  logic                 wbValid,
    input  logic [BITS_ADDR-1:0] wbAddr,
    input  logic [BITS_DATA-1:0] wbData,
    output logic                 exValid,
    input  logic                 exReady,
    output logic [BITS_DATA-1:0] exOp1,
    output logic [BITS_DATA-1:0] exOp2,
    output logic [BITS_ADDR-1:0] exRd,
    output logic                 exWe
);

    localparam int NUM_REGS = 1 << BITS_ADDR;

    typedef enum logic [1:0] {IDLE, WAIT, OUT} stateType;

    stateType             stateReg, stateNext;
    logic [BITS_ADDR-1:0] rs1Reg, rs2Reg, rdReg;
    logic                 weReg;
    logic [BITS_DATA-1:0] op1Reg, op2Reg;
    logic [NUM_REGS-1:0]  busyReg, busyNext;

    logic bypass1, bypass2, ready1, ready2;
    logic accept, capture, exFire;

    // A source is usable if no producer is outstanding, or its producer writes back now
    assign bypass1 = wbValid && (wbAddr == rs1Reg);
    assign bypass2 = wbValid && (wbAddr == rs2Reg);
    assign ready1  = !busyReg[rs1Reg] || bypass1;
    assign ready2  = !busyReg[rs2Reg] || bypass2;

    always_comb begin
        stateNext  = stateReg;
        issueReady = 1'b0;
        exValid    = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        exFire     = 1'b0;
        case (stateReg)
            IDLE: begin
                issueReady = 1'b1;
                if (issueValid) begin
                    accept    = 1'b1;
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                if (ready1 && ready2) begin
                    capture   = 1'b1;
                    stateNext = OUT;
                end
            end
            OUT: begin
                exValid = 1'b1;
                if (exReady) begin
                    exFire    = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Set beats clear on the same index: the issuing instruction is the younger producer
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : genBusy
            logic setBit, clrBit;
            assign setBit       = exFire && weReg && (rdReg == BITS_ADDR'(gi));
            assign clrBit       = wbValid && (wbAddr == BITS_ADDR'(gi));
            assign busyNext[gi] = setBit || (busyReg[gi] && !clrBit);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg <= IDLE;
            busyReg  <= '0;
            rs1Reg   <= '0;
            rs2Reg   <= '0;
            rdReg    <= '0;
            weReg    <= 1'b0;
            op1Reg   <= '0;
            op2Reg   <= '0;
        end else begin
            stateReg <= stateNext;
            busyReg  <= busyNext;
            if (accept) begin
                rs1Reg <= issueRs1;
                rs2Reg <= issueRs2;
                rdReg  <= issueRd;
                weReg  <= issueWe;
            end
            if (capture) begin
                op1Reg <= bypass1 ? wbData : rfData1;
                op2Reg <= bypass2 ? wbData : rfData2;
            end
        end
    end

    assign rfAddr1 = rs1Reg;
    assign rfAddr2 = rs2Reg;
    assign exOp1   = op1Reg;
    assign exOp2   = op2Reg;
    assign exRd    = rdReg;
    assign exWe    = weReg;

endmodule

// File: tb/tb_operand_fetch.sv
// Randomized bench for operand_fetch: a driver predicts each instruction's operands and
// latency from architectural register state, a monitor checks what execute sees.
module tb_operand_fetch;

    logic        clk;
    logic        rst_n;
    logic        issueValid;
    logic        issueReady;
    logic [2:0]  issueRs1, issueRs2, issueRd;
    logic        issueWe;
    logic [2:0]  rfAddr1, rfAddr2;
    logic [31:0] rfData1, rfData2;
    logic        wbValid;
    logic [2:0]  wbAddr;
    logic [31:0] wbData;
    logic        exValid;
    logic        exReady;
    logic [31:0] exOp1, exOp2;
    logic [2:0]  exRd;
    logic        exWe;

    operand_fetch #(.BITS_DATA(32), .BITS_ADDR(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .issueValid(issueValid), .issueReady(issueReady),
        .issueRs1(issueRs1), .issueRs2(issueRs2), .issueRd(issueRd), .issueWe(issueWe),
        .rfAddr1(rfAddr1), .rfAddr2(rfAddr2), .rfData1(rfData1), .rfData2(rfData2),
        .wbValid(wbValid), .wbAddr(wbAddr), .wbData(wbData),
        .exValid(exValid), .exReady(exReady), .exOp1(exOp1), .exOp2(exOp2),
        .exRd(exRd), .exWe(exWe)
    );

    // Architectural register file (combinational read) and outstanding-producer set
    logic [31:0] regs [8];
    logic [7:0]  busyM;
    assign rfData1 = regs[rfAddr1];
    assign rfData2 = regs[rfAddr2];

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [2:0]  rd;
        logic        we;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;
    logic hsFlag;
    logic [2:0] curRd;
    logic curWe;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: scoreboard front is the instruction currently presented to execute
    initial begin
        bit   active;
        exp_t cur;
        int   acceptCyc;
        active    = 0;
        acceptCyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                if (active) begin
                    void'(sb.pop_front());
                    active = 0;
                end
            end else begin
                if (exValid) begin
                    if (!active) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_exValid", 32'(exValid), 32'd0);
                        end else begin
                            active = 1;
                            cur    = sb[0];
                            chk("latency", 32'(cyc - acceptCyc), 32'(cur.lat));
                        end
                    end
                    if (active) begin
                        chk("exOp1", exOp1, cur.op1);
                        chk("exOp2", exOp2, cur.op2);
                        chk("exRd", 32'(exRd), 32'(cur.rd));
                        chk("exWe", 32'(exWe), 32'(cur.we));
                        chk("issueReady_in_out", 32'(issueReady), 32'd0);
                        if (exReady) begin
                            $display("txn done: rd=%0d we=%0d op1=%h op2=%h lat=%0d",
                                     cur.rd, cur.we, cur.op1, cur.op2, cur.lat);
                            void'(sb.pop_front());
                            active = 0;
                        end
                    end
                end
                if (issueValid && issueReady) acceptCyc = cyc + 1;
            end
        end
    end

    // One cycle; model state follows the writeback/handshake that was driven into that edge
    task automatic step();
        @(posedge clk);
        #1;
        if (wbValid) begin
            regs[wbAddr]  = wbData;
            busyM[wbAddr] = 1'b0;
        end
        if (hsFlag && curWe) busyM[curRd] = 1'b1;
    endtask

    task automatic doTxn(input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rd,
                         input logic we, input int dly, input logic [31:0] pendData,
                         input int stallOut, input bit collide, input bit resetInOut);
        logic [31:0] nv [8];
        logic [2:0]  pend[$];
        logic [31:0] pd;
        exp_t        e;
        nv = regs;
        pd = pendData;
        if (busyM[rs1]) begin
            pend.push_back(rs1);
            nv[rs1] = pd;
            pd = ~pd;
        end
        if (busyM[rs2] && rs2 != rs1) begin
            pend.push_back(rs2);
            nv[rs2] = pd;
        end
        e.op1 = nv[rs1];
        e.op2 = nv[rs2];
        e.rd  = rd;
        e.we  = we;
        e.lat = (pend.size() == 0) ? 1 : pend.size() * (dly + 1);
        chk("issueReady_idle", 32'(issueReady), 32'd1);
        sb.push_back(e);
        issueValid = 1'b1;
        issueRs1 = rs1; issueRs2 = rs2; issueRd = rd; issueWe = we;
        step();
        issueValid = 1'b0;
        if (pend.size() == 0) begin
            step();
        end else begin
            for (int i = 0; i < pend.size(); i++) begin
                repeat (dly) step();
                wbValid = 1'b1;
                wbAddr  = pend[i];
                wbData  = nv[pend[i]];
                step();
                wbValid = 1'b0;
            end
        end
        repeat (stallOut) begin
            if ($urandom_range(0, 1) == 1) begin
                wbValid = 1'b1;
                wbAddr  = 3'($urandom_range(0, 7));
                wbData  = $urandom;
            end
            step();
            wbValid = 1'b0;
        end
        if (resetInOut) begin
            #2 rst_n = 1'b0;
            #1;
            chk("rst_exValid", 32'(exValid), 32'd0);
            chk("rst_issueReady", 32'(issueReady), 32'd1);
            chk("rst_exOp1", exOp1, 32'd0);
            chk("rst_exOp2", exOp2, 32'd0);
            chk("rst_exRd", 32'(exRd), 32'd0);
            chk("rst_exWe", 32'(exWe), 32'd0);
            chk("rst_rfAddr1", 32'(rfAddr1), 32'd0);
            chk("rst_rfAddr2", 32'(rfAddr2), 32'd0);
            busyM = '0;
            @(posedge clk);
            #1 rst_n = 1'b1;
        end else begin
            exReady = 1'b1;
            curRd   = rd;
            curWe   = we;
            hsFlag  = 1'b1;
            if (collide) begin
                wbValid = 1'b1;
                wbAddr  = rd;
                wbData  = $urandom;
            end else if ($urandom_range(0, 3) == 0) begin
                wbValid = 1'b1;
                wbAddr  = 3'($urandom_range(0, 7));
                wbData  = $urandom;
            end
            step();
            exReady = 1'b0;
            hsFlag  = 1'b0;
            wbValid = 1'b0;
        end
    endtask

    initial begin
        int guard;
        rst_n = 1'b0; issueValid = 1'b0; issueRs1 = '0; issueRs2 = '0; issueRd = '0;
        issueWe = 1'b0; wbValid = 1'b0; wbAddr = '0; wbData = '0; exReady = 1'b0;
        hsFlag = 1'b0; curRd = '0; curWe = 1'b0; busyM = '0;
        for (int i = 0; i < 8; i++) regs[i] = $urandom;
        regs[3] = 32'h11;
        regs[5] = 32'h22;
        #12;
        chk("init_issueReady", 32'(issueReady), 32'd1);
        chk("init_exValid", 32'(exValid), 32'd0);
        chk("init_exOp1", exOp1, 32'd0);
        chk("init_exRd", 32'(exRd), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        doTxn(3'd3, 3'd5, 3'd6, 1'b1, 0, 32'h0, 0, 1'b0, 1'b0);      // no hazard
        doTxn(3'd6, 3'd3, 3'd0, 1'b0, 2, 32'hDEAD, 0, 1'b0, 1'b0);   // RAW stall + bypass
        doTxn(3'd6, 3'd6, 3'd1, 1'b0, 0, 32'h0, 0, 1'b0, 1'b0);      // busy[6] cleared
        doTxn(3'd5, 3'd3, 3'd1, 1'b0, 0, 32'h0, 5, 1'b0, 1'b0);      // backpressure
        doTxn(3'd1, 3'd1, 3'd2, 1'b1, 0, 32'h0, 0, 1'b1, 1'b0);      // set/clear collision
        doTxn(3'd2, 3'd5, 3'd3, 1'b0, 2, 32'h12345678, 0, 1'b0, 1'b0);
        doTxn(3'd0, 3'd0, 3'd4, 1'b0, 0, 32'h0, 0, 1'b0, 1'b0);      // non-writing
        doTxn(3'd4, 3'd0, 3'd5, 1'b0, 2, 32'h0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            doTxn(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom,
                  $urandom_range(0, 3), ($urandom_range(0, 3) == 0), 1'b0);
        end

        // Reset mid-OUT with a producer outstanding on R7; afterwards R7 reads without a stall
        doTxn(3'd1, 3'd2, 3'd7, 1'b1, 0, 32'h0, 0, 1'b0, 1'b0);
        doTxn(3'd3, 3'd4, 3'd5, 1'b0, 0, 32'h0, 3, 1'b0, 1'b1);
        doTxn(3'd7, 3'd7, 3'd0, 1'b0, 2, 32'hBEEF, 0, 1'b0, 1'b0);

        guard = 0;
        while (sb.size() != 0 && guard < 50) begin
            step();
            guard++;
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
